// File: rtl/mdu_pkg.sv
// Shared constants and encodings for the multiply/divide unit.
package mdu_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;
endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mdu_abs_neg
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0] val_i,
  input  logic            neg_i,
  output logic [XLEN-1:0] val_o
);
  assign val_o = neg_i ? (~val_i + XLEN'(1)) : val_i;
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring, magnitude + sign fix-up).
// Handshake: a start strobe is accepted only in IDLE; done pulses one cycle with hi/lo valid.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            mult_start,
  input  logic            div_start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output state_e          state_dbg
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // acc holds the Booth accumulator for mult and the partial remainder for div.
  logic [XLEN:0]     acc_q, acc_d;
  logic [XLEN-1:0]   q_q, q_d;
  logic              q1_q, q1_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic              zero_q, zero_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [XLEN-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [XLEN:0]     mcand_ext, booth_sum, rem_sh, trial;
  logic              op_sel;

  mdu_abs_neg u_abs_a (.val_i(op_a),               .neg_i(op_a[XLEN-1]), .val_o(abs_a));
  mdu_abs_neg u_abs_b (.val_i(op_b),               .neg_i(op_b[XLEN-1]), .val_o(abs_b));
  mdu_abs_neg u_fix_q (.val_i(q_q),                .neg_i(neg_quo_q),    .val_o(quo_fix));
  mdu_abs_neg u_fix_r (.val_i(acc_q[XLEN-1:0]),    .neg_i(neg_rem_q),    .val_o(rem_fix));

  assign op_sel    = mult_start ? OP_MULT : OP_DIV;
  assign mcand_ext = {mcand_q[XLEN-1], mcand_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    mcand_d   = mcand_q;
    zero_d    = zero_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    booth_sum = acc_q;
    rem_sh    = '0;
    trial     = '0;
    case (state_q)
      ST_IDLE: begin
        if (mult_start || div_start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          acc_d  = '0;
          zero_d = 1'b0;
          if (op_sel == OP_MULT) begin
            mcand_d = op_a;
            q_d     = op_b;
            q1_d    = 1'b0;
            state_d = ST_MULT;
          end else if (op_b == '0) begin
            zero_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            mcand_d   = abs_b;
            q_d       = abs_a;
            neg_quo_d = op_a[XLEN-1] ^ op_b[XLEN-1];
            neg_rem_d = op_a[XLEN-1];
            state_d   = ST_DIV;
          end
        end
      end
      ST_MULT: begin
        case ({q_q[0], q1_q})
          2'b01:   booth_sum = acc_q + mcand_ext;
          2'b10:   booth_sum = acc_q - mcand_ext;
          default: booth_sum = acc_q;
        endcase
        acc_d = {booth_sum[XLEN], booth_sum[XLEN:1]};
        q_d   = {booth_sum[0], q_q[XLEN-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIN;
      end
      ST_DIV: begin
        rem_sh = {acc_q[XLEN-1:0], q_q[XLEN-1]};
        trial  = rem_sh - {1'b0, mcand_q};
        acc_d  = trial[XLEN] ? rem_sh : trial;
        q_d    = {q_q[XLEN-2:0], ~trial[XLEN]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        q_d     = quo_fix;
        acc_d   = {1'b0, rem_fix};
        state_d = ST_FIN;
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        // Mult and div both leave the high word in acc and the low word in q.
        if (zero_q) begin
          dz_d = 1'b1;
        end else begin
          hi_d = acc_q[XLEN-1:0];
          lo_d = q_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      mcand_q   <= '0;
      zero_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      mcand_q   <= mcand_d;
      zero_q    <= zero_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, busy window, results and strobe handling.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            mult_start = 1'b0;
  logic            div_start = 1'b0;
  logic [31:0]     op_a = '0;
  logic [31:0]     op_b = '0;
  logic [31:0]     hi, lo;
  logic            busy, done, div_zero;
  state_e          state_dbg;

  int              checks = 0;
  int              errors = 0;
  logic [63:0]     exp_q[$];

  mult_div_unit dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .op_a(op_a), .op_b(op_b), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_zero(div_zero), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; counts edges since the start edge (inclusive) until done is seen.
  task automatic wait_done(input int poke_at, output int lat, output int nbusy);
    lat = 1;
    nbusy = 0;
    while (!done && lat < 200) begin
      if (busy) nbusy++;
      div_start = (lat == poke_at);
      @(negedge clk);
      lat++;
    end
    div_start = 1'b0;
  endtask

  // Called at a negedge; the strobe is presented to the next posedge.
  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input logic exp_dz,
                        input int exp_lat, input int poke_at);
    int lat, nb;
    logic [63:0] e;
    exp_q.push_back(exp_res);
    op_a = a; op_b = b; mult_start = m; div_start = d;
    @(posedge clk);
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    op_a = $urandom; op_b = $urandom;
    wait_done(poke_at, lat, nb);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_lat - 1));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
    e = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, e);
  endtask

  initial begin
    int extra_done;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);

    run_op("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 64'hFFFFFFFF_FFFFFFEB, 0, 34, 0);
    @(negedge clk);
    check("mul_7_m3_done_clear", 64'(done), 64'd0);

    run_op("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, 0, 34, 0);
    // issued in the done cycle: back-to-back acceptance
    run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0, 35, 0);
    @(negedge clk);

    run_op("div_by_zero", 0, 1, 32'd100, 32'd0, 64'hFFFFFFFF_FFFFFFFD, 1, 2, 0);
    @(negedge clk);
    check("div_by_zero_flag_clear", 64'(div_zero), 64'd0);
    check("div_by_zero_busy_after", 64'(busy), 64'd0);

    run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 0, 35, 0);
    @(negedge clk);
    run_op("div_7_m2", 0, 1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 0, 35, 0);
    run_op("div_100_7", 0, 1, 32'd100, 32'd7, 64'h00000002_0000000E, 0, 35, 0);
    @(negedge clk);
    run_op("mul_12345_m1000", 1, 0, 32'd12345, 32'hFFFF_FC18, 64'hFFFFFFFF_FF43A158, 0, 34, 0);
    @(negedge clk);

    // both strobes: mult wins; stray div strobe mid-operation is ignored
    run_op("both_strobes", 1, 1, 32'd6, 32'hFFFF_FFFC, 64'hFFFFFFFF_FFFFFFE8, 0, 34, 10);
    extra_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("both_strobes_no_extra_done", 64'(extra_done), 64'd0);

    // reset during iteration 10 of a divide
    op_a = 32'd1000; op_b = 32'd7; div_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_div_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    run_op("mul_5_6", 1, 0, 32'd5, 32'd6, 64'h00000000_0000001E, 0, 34, 0);
    run_op("mul_m5_m6", 1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'h00000000_0000001E, 0, 34, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit sitting directly downstream of the control unit, started by its MULT_on / DIV_on strobes.
- Operands come from the A/B register outputs. It produces the 64-bit HI/LO result consumed by the Hi/Lo registers (MFHI/MFLO path).
- It also produces the divide-by-zero flag that the control unit turns into an exception.
- Multiply uses radix-2 Booth; divide uses restoring division on magnitudes with sign fix-up.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- mult_start  input  1  one-cycle strobe; begin signed multiply of op_a*op_b.
- div_start  input  1  one-cycle strobe; begin signed divide op_a/op_b.
- op_a  input  XLEN  multiplicand / dividend; sampled only on an accepted start.
- op_b  input  XLEN  multiplier / divisor; sampled only on an accepted start.
- hi  output  XLEN  mult: product[63:32]; div: remainder.
- lo  output  XLEN  mult: product[31:0]; div: quotient.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; hi/lo valid and updated.
- div_zero  output  1  one-cycle pulse; divide attempted with op_b==0.

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. Reset mid-operation aborts immediately and discards partial results.
- States: IDLE, MULT, DIV, FIX, FIN.
- Start acceptance (IDLE only):
  - A start is accepted at edge E0 when the FSM is in IDLE and a start strobe is high.
  - If mult_start and div_start are both high, mult wins.
  - Starts seen in any other state are ignored.
- Accepted mult at E0:
  - Latch op_a, op_b.
  - Booth register {acc=0, q=op_b, q_1=0}.
  - counter=0, busy=1, state=MULT.
- MULT, one step per edge:
  - {q[0],q_1}=01 → acc+=op_a; 10 → acc-=op_a. The add/subtract is XLEN+1 bits wide so -2^31 is handled.
  - Then arithmetic right shift of {acc,q,q_1}; counter++.
  - After XLEN steps (edges E1..E32), go to FIN.
- Accepted div, op_b==0:
  - At E0: state=FIN with a zero flag set, and no iterations.
  - At E1: div_zero=1, done=1, busy=0; hi/lo unchanged.
- Accepted div, op_b!=0:
  - Latch |op_a|, |op_b|, sign_q=a[31]^b[31], sign_r=a[31].
  - rem=0, quo=|op_a|, state=DIV.
- DIV, one step per edge:
  - {rem,quo} <<= 1; trial = rem - |op_b| (XLEN+1 bits).
  - If trial ≥ 0: rem=trial and quo[0]=1.
  - After XLEN steps, go to FIX.
- FIX (1 edge):
  - Negate quo if sign_q.
  - Negate rem if sign_r, so the remainder takes the dividend's sign.
- FIN (1 edge):
  - Write hi/lo.
  - In the following cycle: done=1 and busy=0; state returns to IDLE.
  - done and div_zero clear on the next edge.
- Latency, counting the start edge as E0:
  - Mult: done high in the cycle after E33.
  - Div: done high in the cycle after E34.
  - Div-by-zero: done high in the cycle after E1.
- busy is high from the cycle after E0 until the done cycle.
- A new start is accepted in the done cycle itself, i.e. back-to-back operation.
- Boundary cases:
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Magnitude of 0x80000000 is handled as unsigned 2^31.
- hi/lo hold their last values between operations; they are never partially updated.

Decomposition:
- Shared package mdu_pkg:
  - XLEN and CNT_W constants.
  - State encoding (IDLE, MULT, DIV, FIX, FIN).
  - op-type localparam (OP_MULT, OP_DIV).
- One natural sub-module: mdu_abs_neg, a combinational conditional two's-complement negate, XLEN wide. It is reused for operand abs and result sign fix-up.

Test Plan:
- mult 7 * -3 → after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- mult 0x80000000 * 0x80000000 → hi=0x40000000, lo=0x00000000.
- div -7 / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); done 35 cycles after start.
- div 100 / 0 → next cycle div_zero=1, done=1; hi/lo keep prior values; busy never asserted beyond that.
- mult_start and div_start both high together, then div_start again while busy → multiply result only; the second strobe is ignored with no extra done.
- reset asserted at iteration 10 of a divide → next cycle hi=lo=0, busy=0, done=0; a subsequent mult 5*6 gives lo=30.
